num_sequencer: RTL
==================

// Module: num_sequencer
// PURPOSE
//  Front-end stage feeding the 5-bit number bus of the multiple-detector LED block.
//  - Takes raw push-buttons: up, down, clear.
//  - Synchronises and debounces each button, then edge-detects it.
//  - Steps a registered 0..MAX_VAL value with wrap-around and drives it on number[4:0].
//  - Optional auto-run mode increments the value periodically.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000   consecutive stable cycles to accept a level change (>=2)
//  AUTO_PERIOD      50000000  cycles between auto-run increments (>=2; macro only)
//  MAX_VAL          31        highest value before wrap (1..31)
// PORTS
//  clk             in   1  system clock; single clock domain
//  rst_n           in   1  asynchronous, active-low reset
//  btn_up          in   1  raw button, asynchronous, active-high
//  btn_down        in   1  raw button, asynchronous, active-high
//  btn_clr         in   1  raw button, asynchronous, active-high
//  run_en          in   1  auto-run enable, level (present only with macro)
//  number          out  5  current value, registered; drives detector input
//  number_changed  out  1  1-cycle pulse, high in the same cycle a new value first appears
// BEHAVIOUR
//  - Reset (rst_n low, async): number=0, number_changed=0; all sync flops, debounced
//    levels, debounce counters and prescaler cleared. Normal operation resumes on the
//    first clk edge after rst_n rises.
//  - Sync: 2-flop synchroniser per button.
//  - Debounce, per button:
//    - counter clears in any cycle where sync==debounced level;
//    - otherwise it increments;
//    - when it has counted DEBOUNCE_CYCLES consecutive mismatches, the debounced level
//      takes the sync value and the counter clears.
//    - Glitches shorter than DEBOUNCE_CYCLES produce no event.
//  - Edge: registered 1-cycle press pulse on the debounced 0->1 transition only.
//    A held button yields exactly one step; release yields none.
//  - Latency: raw 0->1 (held stable) to new number = exactly DEBOUNCE_CYCLES+4 clk edges.
//  - Update, evaluated per cycle on the press pulses (priority order):
//    1. clr             -> number=0; also clears prescaler.
//    2. up AND down     -> no change.
//    3. up              -> number = (number==MAX_VAL) ? 0 : number+1.
//    4. down            -> number = (number==0) ? MAX_VAL : number-1.
//  - number_changed: high only when the registered value actually differs from the
//    previous cycle (clr at 0 gives no pulse).
//  - Width: number is 5 bits, unsigned; never exceeds MAX_VAL.
// CONFIGURATION
//  NUM_SEQ_AUTO_RUN_EN defined:
//  - run_en port present; prescaler counts 0..AUTO_PERIOD-1 while run_en=1 and
//    generates a tick at wrap.
//  - tick acts as an up event in the priority table:
//    - tick+up      -> +1 once;
//    - tick+down    -> no change;
//    - tick+clr     -> 0.
//  - run_en=0 clears and holds the prescaler (synchronously).
//  NUM_SEQ_AUTO_RUN_EN undefined:
//  - run_en port, prescaler and ticks absent; AUTO_PERIOD ignored; manual stepping only.
// TESTING (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, MAX_VAL=31)
//  1. Reset with buttons idle -> number=0, number_changed=0; async assert mid-count
//     forces 0 without a clk edge.
//  2. btn_up held 20 cycles -> number 0->1 exactly 8 edges after the press,
//     1 number_changed pulse, no further steps.
//  3. btn_up pulsed 3 cycles -> no change; then 32 clean up presses from 0 -> ends at 0
//     (wrap 31->0 once).
//  4. From 0, one down press -> 31; btn_up and btn_down pressed on the same edge -> no
//     change, no pulse.
//  5. number=17, btn_clr+btn_up together -> 0; clr again at 0 -> no number_changed.
//  6. With macro, run_en=1 from 0 -> +1 every 8 cycles; up press on a tick cycle ->
//     +1 only; run_en=0 -> value holds.

Source files
------------

// File: rtl/num_sequencer.sv
// Button-driven 0..MAX_VAL sequencer: sync, debounce and edge-detect up/down/clear, then step a wrapping value.
// Optional auto-run (periodic increment, run_en port) is enabled by defining NUM_SEQ_AUTO_RUN_EN.
module num_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 50000000,
  parameter int MAX_VAL         = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
`ifdef NUM_SEQ_AUTO_RUN_EN
  input  logic       run_en,
`endif
  output logic [4:0] number,
  output logic       number_changed
);

  localparam int         CW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [4:0] W_MAX = 5'(MAX_VAL);

  // Bit 0 = up, bit 1 = down, bit 2 = clear throughout.
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_d;
  logic [2:0]    r_press;
  logic [CW-1:0] r_cnt [3];
  logic [4:0]    r_number;
  logic          r_changed;
  logic [4:0]    w_next;
  logic          w_inc;
  logic          w_tick;

  assign w_raw = {btn_clr, btn_down, btn_up};

  // The debounce counter only advances while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef NUM_SEQ_AUTO_RUN_EN
  localparam int PW = $clog2(AUTO_PERIOD);
  logic [PW-1:0] r_pre;

  assign w_tick = run_en && (r_pre == PW'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (!run_en || r_press[2] || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end
`else
  assign w_tick = 1'b0;
`endif

  // An auto-run tick behaves exactly like an up press, so tick+up still steps only once.
  assign w_inc = r_press[0] | w_tick;

  always_comb begin
    w_next = r_number;
    if (r_press[2]) begin
      w_next = '0;
    end else if (w_inc && r_press[1]) begin
      w_next = r_number;
    end else if (w_inc) begin
      w_next = (r_number == W_MAX) ? 5'd0 : r_number + 5'd1;
    end else if (r_press[1]) begin
      w_next = (r_number == 5'd0) ? W_MAX : r_number - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_number  <= '0;
      r_changed <= 1'b0;
    end else begin
      r_number  <= w_next;
      r_changed <= (w_next != r_number);
    end
  end

  assign number         = r_number;
  assign number_changed = r_changed;

endmodule
